// File: rtl/sqrt_digit_rec_pkg.sv
// sqrt_digit_rec_pkg
// Shared constants, FSM state type and radicand alignment helper for the
// single-precision FPU square-root path.
//   SQRT_SIG_W  : significand width entering the core
//   SQRT_ROOT_W : integer root width produced by the core
//   SQRT_RAD_W  : radicand width (two radicand bits per root bit)
//   SQRT_REM_W  : partial remainder width (root width + 2 guard bits)
package sqrt_digit_rec_pkg;

    localparam int SQRT_SIG_W  = 24;
    localparam int SQRT_ROOT_W = 44;
    localparam int SQRT_RAD_W  = 88;
    localparam int SQRT_REM_W  = 46;
    localparam int SQRT_ITERS  = 44;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sqrt_state_e;

    // Odd exponents keep the significand at the top of the radicand; even
    // exponents shift it down one place so that the hidden bit still yields
    // root[43]=1 in both cases.
    function automatic logic [SQRT_RAD_W-1:0] sqrt_align(
        input logic [SQRT_SIG_W-1:0] sig,
        input logic                  exp_odd
    );
        return exp_odd ? {sig, 64'b0} : {1'b0, sig, 63'b0};
    endfunction

endpackage

// File: rtl/sqrt_digit_rec_sqrt_step.sv
// sqrt_step
// One combinational restoring square-root iteration.
//   i_rem      : partial remainder before this step
//   i_root     : partial root before this step
//   i_rad_bits : next two radicand bits (MSB first)
//   o_rem      : partial remainder after this step
//   o_root     : partial root after this step (one more bit retired)
module sqrt_step
    import sqrt_digit_rec_pkg::*;
(
    input  logic [SQRT_REM_W-1:0]  i_rem,
    input  logic [SQRT_ROOT_W-1:0] i_root,
    input  logic [1:0]             i_rad_bits,
    output logic [SQRT_REM_W-1:0]  o_rem,
    output logic [SQRT_ROOT_W-1:0] o_root
);

    // Compare at full width so no remainder bit is silently discarded; the
    // bounded remainder keeps the result within SQRT_REM_W bits.
    logic [SQRT_REM_W+1:0] w_rem_sh;
    logic [SQRT_REM_W+1:0] w_trial;
    logic                  w_ge;

    assign w_rem_sh = {i_rem, i_rad_bits};
    assign w_trial  = {2'b00, i_root, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);

    assign o_rem  = SQRT_REM_W'(w_ge ? (w_rem_sh - w_trial) : w_rem_sh);
    assign o_root = {i_root[SQRT_ROOT_W-2:0], w_ge};

endmodule

// File: rtl/sqrt_digit_rec.sv
// sqrt_digit_rec
// Iterative restoring square-root core retiring BPC root bits per clock.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : request pulse, accepted in IDLE or DONE
//   is_exp_odd : radicand alignment select
//   in_sig     : 24-bit significand, hidden bit at [23]
//   sqrt_done  : one-cycle pulse when sqrt_sig/rem_nz are fresh
//   sqrt_sig   : floor(sqrt(X)), held until the next completion
//   rem_nz     : X - sqrt_sig^2 is nonzero
module sqrt_digit_rec
    import sqrt_digit_rec_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   is_exp_odd,
    input  logic [SQRT_SIG_W-1:0]  in_sig,
    output logic                   sqrt_done,
    output logic [SQRT_ROOT_W-1:0] sqrt_sig,
    output logic                   rem_nz
);

    localparam int K     = SQRT_ITERS / BPC;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    if (!(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_bpc
        $error("sqrt_digit_rec: BPC must be 1, 2 or 4");
    end

    sqrt_state_e            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [SQRT_RAD_W-1:0]  r_rad;
    logic [SQRT_REM_W-1:0]  r_rem;
    logic [SQRT_ROOT_W-1:0] r_root;
    logic                   r_done;
    logic [SQRT_ROOT_W-1:0] r_sig;
    logic                   r_rem_nz;

    logic [SQRT_REM_W-1:0]  w_rem_fin;
    logic [SQRT_ROOT_W-1:0] w_root_fin;

    // Chain of BPC steps; stage gi consumes radicand bit pair gi counted
    // from the MSB of the shift register.
    for (genvar gi = 0; gi < BPC; gi++) begin : g_step
        logic [SQRT_REM_W-1:0]  w_rem_i;
        logic [SQRT_ROOT_W-1:0] w_root_i;
        logic [SQRT_REM_W-1:0]  w_rem_o;
        logic [SQRT_ROOT_W-1:0] w_root_o;

        if (gi == 0) begin : g_first
            assign w_rem_i  = r_rem;
            assign w_root_i = r_root;
        end else begin : g_next
            assign w_rem_i  = g_step[gi-1].w_rem_o;
            assign w_root_i = g_step[gi-1].w_root_o;
        end

        sqrt_step u_step (
            .i_rem      (w_rem_i),
            .i_root     (w_root_i),
            .i_rad_bits (r_rad[SQRT_RAD_W-1-2*gi -: 2]),
            .o_rem      (w_rem_o),
            .o_root     (w_root_o)
        );
    end

    assign w_rem_fin  = g_step[BPC-1].w_rem_o;
    assign w_root_fin = g_step[BPC-1].w_root_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rad    <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_done   <= 1'b0;
            r_sig    <= '0;
            r_rem_nz <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_rad   <= sqrt_align(in_sig, is_exp_odd);
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_cnt   <= CNT_W'(K - 1);
                        r_state <= BUSY;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    r_rem  <= w_rem_fin;
                    r_root <= w_root_fin;
                    r_rad  <= r_rad << (2 * BPC);
                    if (r_cnt == '0) begin
                        // Results are captured straight from the last step
                        // group so they are valid together with the pulse.
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_sig    <= w_root_fin;
                        r_rem_nz <= |w_rem_fin;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sqrt_done = r_done;
    assign sqrt_sig  = r_sig;
    assign rem_nz    = r_rem_nz;

endmodule

// File: tb/tb_sqrt_digit_rec.sv
// tb_sqrt_digit_rec
// Drives three instances (BPC = 1, 2, 4) with a shared stimulus stream and
// checks each against a scoreboard of reference results and latencies.
module tb_sqrt_digit_rec;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_exp_odd;
    logic [23:0] in_sig;

    logic [2:0]  done_v;
    logic [2:0]  rem_v;
    logic [43:0] sig_v [3];
    logic [2:0]  done_prev = 3'b000;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [43:0] sig;
        logic        rnz;
        int unsigned cyc;
    } sb_t;

    sb_t sb_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        sqrt_digit_rec #(.BPC(1 << gi)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .is_exp_odd (is_exp_odd),
            .in_sig     (in_sig),
            .sqrt_done  (done_v[gi]),
            .sqrt_sig   (sig_v[gi]),
            .rem_nz     (rem_v[gi])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference by bitwise search on root^2 <= X (square-and-compare).
    function automatic logic [43:0] isqrt(input logic [87:0] x);
        logic [43:0] r;
        logic [43:0] c;
        logic [87:0] sq;
        r = '0;
        for (int b = 43; b >= 0; b--) begin
            c  = r | (44'd1 << b);
            sq = {44'd0, c} * {44'd0, c};
            if (sq <= x) r = c;
        end
        return r;
    endfunction

    // Monitor: pop one expected entry per sqrt_done pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) begin
                if (done_prev[i]) chk($sformatf("done_width%0d", i), 2, 1);
                if (sb_q[i].size() == 0) begin
                    chk($sformatf("spurious_done%0d", i), 1, 0);
                end else begin
                    sb_t e;
                    e = sb_q[i].pop_front();
                    $display("txn bpc=%0d sig=%011h rnz=%0b exp_sig=%011h exp_rnz=%0b lat=%0d",
                             1 << i, sig_v[i], rem_v[i], e.sig, e.rnz, cyc - e.cyc);
                    chk($sformatf("sig%0d", i), 64'(sig_v[i]), 64'(e.sig));
                    chk($sformatf("rnz%0d", i), 64'(rem_v[i]), 64'(e.rnz));
                    chk($sformatf("lat%0d", i), 64'(cyc - e.cyc), 64'(44 / (1 << i)));
                end
            end
        end
        done_prev <= done_v;
    end

    // Drive start at a negedge; the following posedge is the start edge.
    task automatic issue(input logic [23:0] s, input logic odd);
        logic [87:0] x;
        logic [43:0] r;
        sb_t         e;
        x     = odd ? {s, 64'b0} : {1'b0, s, 63'b0};
        r     = isqrt(x);
        e.sig = r;
        e.rnz = ((x - {44'd0, r} * {44'd0, r}) != 88'd0);
        e.cyc = cyc + 1;
        for (int i = 0; i < 3; i++) sb_q[i].push_back(e);
        start      = 1'b1;
        in_sig     = s;
        is_exp_odd = odd;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done1();
        int n;
        n = 0;
        while (!done_v[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done_v[0]) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_done%0d", tag, i), 64'(done_v[i]), 0);
            chk($sformatf("%s_sig%0d", tag, i), 64'(sig_v[i]), 0);
            chk($sformatf("%s_rnz%0d", tag, i), 64'(rem_v[i]), 0);
        end
    endtask

    initial begin
        logic [23:0] s;
        reset      = 1'b0;
        start      = 1'b0;
        is_exp_odd = 1'b0;
        in_sig     = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // 1.0 with even exponent: root is exactly 2^43.
        issue(24'h800000, 1'b0);
        wait_done1();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d1_sig%0d", i), 64'(sig_v[i]), 64'h80000000000);
            chk($sformatf("d1_rnz%0d", i), 64'(rem_v[i]), 0);
        end

        // Back-to-back: start held during the DONE cycle.
        issue(24'h900000, 1'b1);
        wait_done1();
        chk("d2_sig", 64'(sig_v[0]), 64'hC0000000000);
        chk("d2_rnz", 64'(rem_v[0]), 0);

        issue(24'h800000, 1'b1);
        wait_done1();
        chk("d3_msb", 64'(sig_v[0][43]), 1);
        chk("d3_rnz", 64'(rem_v[0]), 1);

        issue(24'h000001, 1'b1);
        wait_done1();
        chk("d4_sig", 64'(sig_v[0]), 64'h00100000000);
        chk("d4_rnz", 64'(rem_v[0]), 0);

        issue(24'h000000, 1'b0);
        wait_done1();
        chk("d5_sig", 64'(sig_v[0]), 0);
        chk("d5_rnz", 64'(rem_v[0]), 0);

        // Restart attempt and input change in the middle of BUSY.
        issue(24'hA5A5A5, 1'b1);
        repeat (9) @(negedge clk);
        start      = 1'b1;
        in_sig     = 24'h123456;
        is_exp_odd = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        in_sig = 24'hFFFFFF;
        wait_done1();
        @(negedge clk);

        // Reset in the middle of an operation.
        issue(24'hC00000, 1'b0);
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) sb_q[i].delete();
        repeat (60) @(negedge clk);
        issue(24'hB504F3, 1'b1);
        wait_done1();

        // Random sweep, back-to-back operations.
        for (int k = 0; k < 1000; k++) begin
            s = 24'($urandom);
            if (k % 8 == 0) s = s >> $urandom_range(23, 1);
            issue(s, 1'($urandom_range(1, 0)));
            wait_done1();
        end

        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("sb_empty%0d", i), 64'(sb_q[i].size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
